// File: rtl/limn2600_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the Limn2600 SRAM bus.
// One transaction in flight; slave-side request is registered at grant.
// Optional slave-response watchdog: define LIMN_ARB_TIMEOUT_EN.
module limn2600_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cs,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  output logic          m0_err,
  input  logic          m1_cs,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          m1_err,
  output logic          s_cs,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          s_cs_q, s_cs_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          win;
  logic          tmo;
  logic          cpl;

`ifdef LIMN_ARB_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

  logic [CW-1:0] cnt_q, cnt_d;

  // Watchdog: held at zero outside BUSY, counts BUSY cycles without s_rdy.
  always_comb begin
    cnt_d = cnt_q;
    tmo   = 1'b0;
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (!s_rdy) begin
      cnt_d = cnt_q + CW'(1);
      tmo   = (cnt_q == CW'(TIMEOUT - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // No watchdog: BUSY waits for s_rdy indefinitely.
  always_comb begin
    tmo = 1'b0;
  end
`endif

  // Next-state: round-robin pick in IDLE, release on completion, one dead TURN cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s_cs_d    = s_cs_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    gnt_d     = gnt_q;
    cpl       = (state_q == BUSY) && (s_rdy || tmo);
    // m1 wins when alone, or on a tie when m0 was served last.
    win       = m1_cs & (~m0_cs | ~last_q);
    case (state_q)
      IDLE: begin
        if (m0_cs || m1_cs) begin
          s_cs_d    = 1'b1;
          s_we_d    = win ? m1_we    : m0_we;
          s_addr_d  = win ? m1_addr  : m0_addr;
          s_wdata_d = win ? m1_wdata : m0_wdata;
          gnt_d     = win ? 2'b10 : 2'b01;
          last_d    = win;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cpl) begin
          s_cs_d  = 1'b0;
          s_we_d  = 1'b0;
          gnt_d   = 2'b00;
          state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and slave-side request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      s_cs_q    <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      s_cs_q    <= s_cs_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      gnt_q     <= gnt_d;
    end
  end

  // Master-side responses: completion steered to the granted master only.
  always_comb begin
    m0_rdy   = cpl & gnt_q[0];
    m1_rdy   = cpl & gnt_q[1];
    m0_err   = tmo & gnt_q[0];
    m1_err   = tmo & gnt_q[1];
    m0_rdata = tmo ? '1 : s_rdata;
    m1_rdata = tmo ? '1 : s_rdata;
    s_cs     = s_cs_q;
    s_we     = s_we_q;
    s_addr   = s_addr_q;
    s_wdata  = s_wdata_q;
    gnt      = gnt_q;
  end

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Directed bench for limn2600_bus_arbiter with a scoreboard of expected
// completions, a behavioural slave with per-transaction latency, and
// master drivers that hold cs until rdy.
module tb_limn2600_bus_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mcs, mwe;
  logic [31:0]   maddr [2];
  logic [31:0]   mwdata [2];
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_rdy, m1_rdy, m0_err, m1_err;
  logic          s_cs, s_we, s_rdy;
  logic [31:0]   s_addr, s_wdata, s_rdata;
  logic [1:0]    gnt;

  limn2600_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cs(mcs[0]), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
    .m0_rdata(m0_rdata), .m0_rdy(m0_rdy), .m0_err(m0_err),
    .m1_cs(mcs[1]), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
    .m1_rdata(m1_rdata), .m1_rdy(m1_rdy), .m1_err(m1_err),
    .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_rdy(s_rdy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          chk_rdata;
    logic        err;
    int unsigned lat;   // 0 = slave never answers
  } exp_t;

  typedef struct {
    int unsigned m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          drop;  // release cs once granted
  } req_t;

  exp_t        sb [$];
  req_t        rq [$];
  logic [31:0] mem [logic [31:0]];
  int unsigned rise_q [$];
  int unsigned rdy_q [$];
  int unsigned issue_cyc [2];
  bit [1:0]    issued, done;
  bit          spur, scs_prev;
  int unsigned cyc, scnt;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push_req(input int unsigned m, input logic we, input logic [31:0] a,
                                   input logic [31:0] d, input bit drop);
    req_t r;
    r.m = m; r.we = we; r.addr = a; r.wdata = d; r.drop = drop;
    rq.push_back(r);
  endfunction

  function automatic void push_exp(input int unsigned m, input logic we, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] rd, input bit chkrd,
                                   input logic err, input int unsigned lat);
    exp_t e;
    e.m = m; e.we = we; e.addr = a; e.wdata = d; e.rdata = rd;
    e.chk_rdata = chkrd; e.err = err; e.lat = lat;
    sb.push_back(e);
  endfunction

  function automatic int find_req(input int unsigned m);
    foreach (rq[i]) if (rq[i].m == m) return i;
    return -1;
  endfunction

  // Sample phase (negedge): slave write commit and scoreboard compare.
  task automatic monitor();
    exp_t e;
    if (s_cs && s_rdy && s_we) mem[s_addr] = s_wdata;
    if (sb.size() == 0) begin
      chk("no_rdy_when_idle", {30'd0, m1_rdy, m0_rdy}, 32'd0);
    end else if (m0_rdy || m1_rdy) begin
      e = sb.pop_front();
      rdy_q.push_back(cyc);
      chk("rdy_onehot", {30'd0, m1_rdy, m0_rdy}, 32'd1 << e.m);
      chk("gnt", {30'd0, gnt}, 32'd1 << e.m);
      chk("s_addr", s_addr, e.addr);
      chk("s_we", {31'd0, s_we}, {31'd0, e.we});
      if (e.we) chk("s_wdata", s_wdata, e.wdata);
      if (e.chk_rdata) chk("rdata", (e.m == 1) ? m1_rdata : m0_rdata, e.rdata);
      chk("err", {30'd0, m1_err, m0_err}, 32'(e.err) << e.m);
      done[e.m] = 1'b1;
    end else begin
      chk("err_quiet", {30'd0, m1_err, m0_err}, 32'd0);
    end
  endtask

  // Drive phase (just after posedge): masters and slave model.
  task automatic drive();
    int idx;
    for (int m = 0; m < 2; m++) begin
      idx = find_req(m);
      if (done[m]) begin
        if (idx >= 0) rq.delete(idx);
        issued[m] = 1'b0;
        done[m]   = 1'b0;
        idx       = find_req(m);
      end
      if (!issued[m]) begin
        if (idx >= 0) begin
          mcs[m]       = 1'b1;
          mwe[m]       = rq[idx].we;
          maddr[m]     = rq[idx].addr;
          mwdata[m]    = rq[idx].wdata;
          issued[m]    = 1'b1;
          issue_cyc[m] = cyc;
        end else begin
          mcs[m] = 1'b0;
        end
      end else if (idx >= 0 && rq[idx].drop && gnt[m]) begin
        mcs[m] = 1'b0;
      end
    end
    if (s_cs) scnt++; else scnt = 0;
    s_rdy   = spur || (s_cs && sb.size() > 0 && sb[0].lat != 0 && scnt == sb[0].lat);
    s_rdata = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
    if (s_cs && !scs_prev) rise_q.push_back(cyc);
    scs_prev = s_cs;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_complete"}, 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mcs = '0; mwe = '0;
    maddr[0] = '0; maddr[1] = '0; mwdata[0] = '0; mwdata[1] = '0;
    s_rdy = 1'b0; s_rdata = '0; spur = 1'b0; scs_prev = 1'b0;
    cyc = 0; scnt = 0; checks = 0; errors = 0; issued = '0; done = '0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h0000_A200;
    mem[32'h201] = 32'h0000_B201;
    mem[32'h202] = 32'h0000_C202;
    mem[32'h203] = 32'h0000_D203;

    // Reset state
    repeat (2) tick();
    chk("rst_s_cs", {31'd0, s_cs}, 32'd0);
    chk("rst_s_we", {31'd0, s_we}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_rdy_err", {28'd0, m1_rdy, m0_rdy, m1_err, m0_err}, 32'd0);
    rst = 1'b0;

    // m0 read 0x100, slave answers on the 2nd BUSY cycle
    rise_q.delete(); rdy_q.delete();
    push_req(0, 1'b0, 32'h100, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2);
    run("m0_read", 20);
    chk("m0_read_rises", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() == 1) chk("m0_read_cs_latency", 32'(rise_q[0] - issue_cyc[0]), 32'd1);
    if (rise_q.size() == 1 && rdy_q.size() == 1)
      chk("m0_read_rdy_latency", 32'(rdy_q[0] - rise_q[0]), 32'd1);

    // Both masters held from reset: m0, m1, m0, m1 at 3-cycle spacing
    do_reset();
    rise_q.delete(); rdy_q.delete();
    push_req(0, 1'b0, 32'h200, 32'h0, 1'b0);
    push_req(1, 1'b0, 32'h201, 32'h0, 1'b0);
    push_req(0, 1'b0, 32'h202, 32'h0, 1'b0);
    push_req(1, 1'b0, 32'h203, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h200, 32'h0, 32'h0000_A200, 1'b1, 1'b0, 1);
    push_exp(1, 1'b0, 32'h201, 32'h0, 32'h0000_B201, 1'b1, 1'b0, 1);
    push_exp(0, 1'b0, 32'h202, 32'h0, 32'h0000_C202, 1'b1, 1'b0, 1);
    push_exp(1, 1'b0, 32'h203, 32'h0, 32'h0000_D203, 1'b1, 1'b0, 1);
    run("round_robin", 40);
    chk("rr_rises", 32'(rise_q.size()), 32'd4);
    if (rise_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd3);
    end

    // m1 write, then m0 reads it back
    push_req(1, 1'b1, 32'h20, 32'h55AA55AA, 1'b0);
    push_exp(1, 1'b1, 32'h20, 32'h55AA55AA, 32'h0, 1'b0, 1'b0, 1);
    run("m1_write", 20);
    push_req(0, 1'b0, 32'h20, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h20, 32'h0, 32'h55AA55AA, 1'b1, 1'b0, 1);
    run("m0_readback", 20);

    // m1 drops cs while granted: transaction still completes, then m0 served normally
    push_req(1, 1'b0, 32'h100, 32'h0, 1'b1);
    push_exp(1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3);
    run("cs_drop", 20);
    push_req(0, 1'b0, 32'h202, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h202, 32'h0, 32'h0000_C202, 1'b1, 1'b0, 1);
    run("after_drop", 20);

    // s_rdy while IDLE is ignored
    spur = 1'b1; s_rdy = 1'b1;
    repeat (3) tick();
    spur = 1'b0; s_rdy = 1'b0;
    chk("spur_gnt", {30'd0, gnt}, 32'd0);
    chk("spur_s_cs", {31'd0, s_cs}, 32'd0);

    // Reset mid-BUSY: outputs clear at once, master reissues and is served
    push_req(0, 1'b0, 32'h100, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    repeat (4) tick();
    chk("busy_gnt", {30'd0, gnt}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_s_cs", {31'd0, s_cs}, 32'd0);
    chk("async_gnt", {30'd0, gnt}, 32'd0);
    chk("async_s_addr", s_addr, 32'd0);
    chk("async_rdy", {30'd0, m1_rdy, m0_rdy}, 32'd0);
    sb.delete();
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2);
    tick();
    rst = 1'b0;
    run("after_reset", 20);

`ifdef LIMN_ARB_TIMEOUT_EN
    // Slave never answers m0: watchdog completes it with err on the 8th BUSY cycle
    do_reset();
    rise_q.delete(); rdy_q.delete();
    push_req(0, 1'b0, 32'h100, 32'h0, 1'b0);
    push_req(1, 1'b0, 32'h201, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 0);
    push_exp(1, 1'b0, 32'h201, 32'h0, 32'h0000_B201, 1'b1, 1'b0, 1);
    run("timeout", 60);
    if (rise_q.size() > 0 && rdy_q.size() > 0)
      chk("timeout_cycle", 32'(rdy_q[0] - rise_q[0]), 32'd7);

    // s_rdy exactly on the 8th BUSY cycle beats the watchdog
    rise_q.delete(); rdy_q.delete();
    push_req(0, 1'b0, 32'h100, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 8);
    run("rdy_at_limit", 40);
    if (rise_q.size() > 0 && rdy_q.size() > 0)
      chk("rdy_at_limit_cycle", 32'(rdy_q[0] - rise_q[0]), 32'd7);
`else
    // Without the watchdog a slow slave is simply waited for
    rise_q.delete(); rdy_q.delete();
    push_req(0, 1'b0, 32'h100, 32'h0, 1'b0);
    push_exp(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 12);
    run("slow_slave", 40);
    if (rise_q.size() > 0 && rdy_q.size() > 0)
      chk("slow_slave_cycle", 32'(rdy_q[0] - rise_q[0]), 32'd11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/limn2600_bus_arbiter.md
Name: limn2600_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the Limn2600 memory bus.
- Shares the single SRAM port between the CPU (master 0) and a second requester (master 1, DMA/debug).
- Uses the same cs/we/addr/data/rdy handshake the SRAM already speaks, so it drops in between the CPU and SRAM.
- Round-robin fairness, one transaction in flight at a time, registered slave-side request.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, slave-response watchdog limit in cycles; used only with LIMN_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0_cs  in  1  master 0 request; held until m0_rdy.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rdata  out  DW  master 0 read data, valid when m0_rdy.
- m0_rdy  out  1  master 0 completion pulse.
- m0_err  out  1  master 0 error, qualified by m0_rdy.
- m1_cs, m1_we, m1_addr, m1_wdata, m1_rdata, m1_rdy, m1_err: same as master 0, for master 1.
- s_cs  out  1  slave select.
- s_we  out  1  slave write enable.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_rdata  in  DW  slave read data.
- s_rdy  in  1  slave completion pulse, one cycle.
- gnt  out  2  one-hot current grant {m1,m0}; 00 when idle.

Behaviour:
- Clocking/reset: one clock (clk); rst asynchronous, active-high. On rst: state=IDLE; s_cs, s_we, gnt, all mN_rdy, all mN_err = 0; s_addr, s_wdata = 0; last = 1 (master 0 wins first tie).
- States: IDLE, BUSY, TURN.
- IDLE:
  - If neither cs is set, stay.
  - If exactly one cs is set, grant that master.
  - If both are set, grant the master != last.
  - On the grant edge: register the winner's we/addr/wdata into s_we/s_addr/s_wdata; set s_cs=1 and gnt; last=winner; go to BUSY.
- BUSY:
  - s_* held constant.
  - mN_rdy = s_rdy & gnt[N] (combinational); mN_rdata = s_rdata (passthrough).
  - On an s_rdy cycle: the next edge clears s_cs and gnt, then go to TURN.
  - Non-granted master sees rdy=0.
- TURN: one dead cycle, so a completing master's stale cs is not re-arbitrated; then go to IDLE.
- Latency: cs seen in IDLE at cycle n -> s_cs high at n+1 -> mN_rdy in the same cycle as s_rdy. With a 1-cycle slave, back-to-back throughput is one transaction per 3 cycles.
- Protocol violation: master drops cs while granted -> the slave transaction still completes; the rdy pulse goes out regardless and is ignored by the master; no state corruption.
- s_rdy while IDLE/TURN: ignored, no mN_rdy.
- Reset mid-BUSY: transaction abandoned immediately; the master must reissue.
- mN_err = 0 at all times without the optional feature.

Optional Feature:
- LIMN_ARB_TIMEOUT_EN
- Defined:
  - An 8..32-bit counter (width clog2(TIMEOUT+1)) clears on entering BUSY and increments each BUSY cycle without s_rdy.
  - On reaching TIMEOUT with no s_rdy: granted master gets mN_rdy=1, mN_err=1, mN_rdata = all ones for one cycle; s_cs drops; go to TURN.
  - s_rdy arriving in the same cycle as the timeout wins: normal completion, err=0.
  - Counter reset value 0.
- Undefined: no counter; BUSY waits indefinitely; mN_err tied 0.

Test Plan:
- m0 read addr 0x100, slave returns 0xDEADBEEF after 2 cycles -> s_cs at n+1, s_addr=0x100, m0_rdy pulse with m0_rdata=0xDEADBEEF, gnt=01, m1_rdy stays 0.
- m0 and m1 both request from reset, each held -> grant order m0, m1, m0, m1; gnt alternates 01/10; each s_cs rise 3 cycles apart with a 1-cycle slave.
- m1 write 0x55AA55AA to 0x20 while m0 idle -> s_we=1, s_wdata=0x55AA55AA, m1_rdy on s_rdy; then m0 read 0x20 returns 0x55AA55AA.
- rst asserted mid-BUSY -> outputs zero asynchronously; after release, the re-requesting master is granted with no spurious rdy.
- Timeout (LIMN_ARB_TIMEOUT_EN, TIMEOUT=8), slave never asserts s_rdy -> m0_rdy=m0_err=1, m0_rdata=0xFFFFFFFF on the 8th BUSY cycle; a pending m1 is then served normally.
- Timeout (LIMN_ARB_TIMEOUT_EN, TIMEOUT=8), s_rdy on exactly the 8th BUSY cycle -> normal completion, m0_err=0.
